vta_host_arb: RTL and testbench
===============================

Name: vta_host_arb

Overview:
Two-requester arbiter sharing the single host register-access port of the VTA control/status register file. Requester 0 is the simulation host request stream; requester 1 is a secondary host (debug/launch sequencer).
- Each request is a read or a write, and only one request is outstanding downstream at a time.
- Read responses are routed back to the originating requester.
- A watchdog returns a poison value if a read response never arrives.

Parameters:
ADDR_BITS, 8, register address width
DATA_BITS, 32, register data width
TIMEOUT_CYCLES, 1024, cycles spent in RESP before the watchdog fires; must be >= 2
TIMEOUT_VALUE, 32'hDEADBEEF, data returned on timeout; truncated or zero-extended to DATA_BITS

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
sN_req_valid  in  1  requester N (N=0,1) has a request
sN_req_opcode  in  1  1=write, 0=read
sN_req_addr  in  ADDR_BITS  register address
sN_req_value  in  DATA_BITS  write data
sN_req_deq  out  1  one-cycle pulse: request N accepted
sN_resp_valid  out  1  one-cycle pulse: read data for requester N
sN_resp_bits  out  DATA_BITS  read data
m_req_valid  out  1  downstream request valid
m_req_opcode  out  1  downstream opcode
m_req_addr  out  ADDR_BITS  downstream address
m_req_value  out  DATA_BITS  downstream write data
m_req_deq  in  1  downstream accepts request
m_resp_valid  in  1  downstream read data valid
m_resp_bits  in  DATA_BITS  downstream read data
grant  out  1  requester owning the current transaction
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on any watchdog expiry

Behaviour:
Reset:
- reset=0 asynchronously clears all registers.
- All outputs go to 0, state goes to IDLE and the round-robin pointer rr goes to 0.
- A reset mid-transaction abandons the transaction with no response, so the in-flight read is lost.
- After reset, any downstream response is ignored while in IDLE.

States: IDLE, REQ, RESP.

IDLE:
- Winner selection:
  - If only one sN_req_valid is high, that requester wins.
  - If both are high, requester rr wins.
- When there is a winner:
  - sN_req_deq is asserted combinationally for the winner in that same cycle.
  - opcode/addr/value are captured into the m_req_* registers.
  - grant is set to the winner.
  - The block moves to REQ.
- sN_req_deq is never high outside IDLE and never for both requesters at once.

REQ:
- m_req_valid=1 and the m_req_* fields are held stable until m_req_deq=1. No bound applies and the watchdog is inactive.
- On m_req_deq, m_req_valid clears on the next edge:
  - Write: rr becomes !grant and the block goes to IDLE.
  - Read: the watchdog counter is cleared and the block goes to RESP.

RESP:
- The counter increments each cycle.
- If m_resp_valid=1:
  - Next cycle, s[grant]_resp_valid pulses for one cycle with s[grant]_resp_bits = m_resp_bits.
  - The other requester's resp_valid stays 0.
  - rr becomes !grant and the block goes to IDLE.
- Otherwise, if counter == TIMEOUT_CYCLES-1:
  - Next cycle, s[grant]_resp_valid pulses with bits = TIMEOUT_VALUE.
  - timeout_err is set.
  - rr becomes !grant and the block goes to IDLE.
- If a response and the timeout occur in the same cycle, the response wins and timeout_err is not set.

Other rules:
- A late response arriving in IDLE/REQ is dropped.
- sN_resp_bits holds its last value when not valid.
- Minimum write turnaround is 2 cycles (IDLE→REQ→IDLE, with m_req_deq in the first REQ cycle).
- A new request can be accepted in the cycle the block returns to IDLE.
- Latency from m_resp_valid to sN_resp_valid is 1 cycle.

Test Plan:
- Reset mid-read (assert reset while in RESP) → all outputs 0 immediately; a subsequent m_resp_valid produces no sN_resp_valid; the next s1 request is accepted normally.
- s0 write addr 0x10 value 0x12345678, m_req_deq high → s0_req_deq pulses in cycle 0; m_req_valid with addr 0x10, value 0x12345678, opcode 1 in cycle 1; no response; busy low by cycle 2.
- s0 and s1 assert writes every cycle continuously → grants alternate 0,1,0,1 starting with 0 after reset; each deq is a single pulse.
- s1 read addr 0x04; m_resp_valid with 0xCAFEF00D three cycles after deq → s1_resp_valid one cycle later with 0xCAFEF00D; s0_resp_valid stays 0.
- s0 read, TIMEOUT_CYCLES=8, downstream never responds → s0_resp_valid with 0xDEADBEEF 9 cycles after m_req_deq; timeout_err=1 and stays high; a late m_resp_valid is ignored.
- m_resp_valid arrives exactly in the timeout cycle with 0x00000055 → returns 0x00000055 and timeout_err remains 0.

Source files
------------

// File: rtl/vta_host_arb_if.sv
// Host register-access request/response bundle.
// The arbiter is the slave on each requester side and the master on the downstream side.
interface vta_host_arb_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 32
) ();
    logic                 req_valid;
    logic                 req_opcode;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_value;
    logic                 req_deq;
    logic                 resp_valid;
    logic [DATA_BITS-1:0] resp_bits;

    modport master (
        output req_valid, req_opcode, req_addr, req_value,
        input  req_deq, resp_valid, resp_bits
    );

    modport slave (
        input  req_valid, req_opcode, req_addr, req_value,
        output req_deq, resp_valid, resp_bits
    );
endinterface

// File: rtl/vta_host_arb.sv
// Two-requester round-robin arbiter for the VTA host CSR port.
// One transaction is outstanding downstream at a time; reads are routed back
// to their originator, and a watchdog returns a poison word if a read stalls.
module vta_host_arb #(
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_VALUE  = 32'hDEADBEEF
) (
    input  logic               clock,
    input  logic               reset,
    vta_host_arb_if.slave      s0,
    vta_host_arb_if.slave      s1,
    vta_host_arb_if.master     m,
    output logic               grant,
    output logic               busy,
    output logic               timeout_err
);
    localparam int unsigned          CNT_W        = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_MAX      = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_BITS-1:0] TIMEOUT_DATA = DATA_BITS'(TIMEOUT_VALUE);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t               state_q, state_n;
    logic                 grant_q, grant_n;
    logic                 rr_q, rr_n;
    logic                 busy_q, busy_n;
    logic                 err_q, err_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 mv_q, mv_n;
    logic                 mop_q, mop_n;
    logic [ADDR_BITS-1:0] maddr_q, maddr_n;
    logic [DATA_BITS-1:0] mval_q, mval_n;
    logic                 rv0_q, rv0_n, rv1_q, rv1_n;
    logic [DATA_BITS-1:0] rb0_q, rb0_n, rb1_q, rb1_n;
    logic [1:0]           deq_c;
    logic                 win;
    logic                 fire;
    logic [DATA_BITS-1:0] resp_data;

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            mv_q    <= 1'b0;
            mop_q   <= 1'b0;
            maddr_q <= '0;
            mval_q  <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rb0_q   <= '0;
            rb1_q   <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            rr_q    <= rr_n;
            busy_q  <= busy_n;
            err_q   <= err_n;
            cnt_q   <= cnt_n;
            mv_q    <= mv_n;
            mop_q   <= mop_n;
            maddr_q <= maddr_n;
            mval_q  <= mval_n;
            rv0_q   <= rv0_n;
            rv1_q   <= rv1_n;
            rb0_q   <= rb0_n;
            rb1_q   <= rb1_n;
        end
    end

    // Next-state, arbitration and response routing.
    always_comb begin
        state_n   = state_q;
        grant_n   = grant_q;
        rr_n      = rr_q;
        err_n     = err_q;
        cnt_n     = cnt_q;
        mv_n      = mv_q;
        mop_n     = mop_q;
        maddr_n   = maddr_q;
        mval_n    = mval_q;
        rv0_n     = 1'b0;
        rv1_n     = 1'b0;
        rb0_n     = rb0_q;
        rb1_n     = rb1_q;
        deq_c     = 2'b00;
        fire      = 1'b0;
        resp_data = m.resp_bits;
        // Contention goes to the round-robin pointer; otherwise to whoever asks.
        win       = (s0.req_valid && s1.req_valid) ? rr_q : s1.req_valid;

        case (state_q)
            IDLE: begin
                if (s0.req_valid || s1.req_valid) begin
                    deq_c   = win ? 2'b10 : 2'b01;
                    mop_n   = win ? s1.req_opcode : s0.req_opcode;
                    maddr_n = win ? s1.req_addr   : s0.req_addr;
                    mval_n  = win ? s1.req_value  : s0.req_value;
                    grant_n = win;
                    mv_n    = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (m.req_deq) begin
                    mv_n = 1'b0;
                    if (mop_q) begin
                        rr_n    = ~grant_q;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = '0;
                        state_n = RESP;
                    end
                end
            end
            RESP: begin
                cnt_n = cnt_q + CNT_W'(1);
                // A real response beats a coincident watchdog expiry.
                if (m.resp_valid) begin
                    fire = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    fire      = 1'b1;
                    resp_data = TIMEOUT_DATA;
                    err_n     = 1'b1;
                end
                if (fire) begin
                    if (grant_q) begin
                        rv1_n = 1'b1;
                        rb1_n = resp_data;
                    end else begin
                        rv0_n = 1'b1;
                        rb0_n = resp_data;
                    end
                    rr_n    = ~grant_q;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // Accept pulses are combinational and forced low while reset is held.
    assign s0.req_deq    = deq_c[0] & reset;
    assign s1.req_deq    = deq_c[1] & reset;
    assign s0.resp_valid = rv0_q;
    assign s0.resp_bits  = rb0_q;
    assign s1.resp_valid = rv1_q;
    assign s1.resp_bits  = rb1_q;
    assign m.req_valid   = mv_q;
    assign m.req_opcode  = mop_q;
    assign m.req_addr    = maddr_q;
    assign m.req_value   = mval_q;
    assign grant         = grant_q;
    assign busy          = busy_q;
    assign timeout_err   = err_q;
endmodule

// File: tb/tb_vta_host_arb.sv
// Self-checking bench for vta_host_arb: scoreboard queues for grants and responses.
module tb_vta_host_arb;
    logic clock = 1'b0;
    logic reset;
    logic grant, busy, timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    int          exp_grant[$];
    logic [31:0] exp_resp0[$];
    logic [31:0] exp_resp1[$];

    vta_host_arb_if #(.ADDR_BITS(8), .DATA_BITS(32)) s0_if ();
    vta_host_arb_if #(.ADDR_BITS(8), .DATA_BITS(32)) s1_if ();
    vta_host_arb_if #(.ADDR_BITS(8), .DATA_BITS(32)) m_if ();

    vta_host_arb #(
        .ADDR_BITS(8), .DATA_BITS(32), .TIMEOUT_CYCLES(8), .TIMEOUT_VALUE(32'hDEADBEEF)
    ) dut (
        .clock(clock), .reset(reset),
        .s0(s0_if), .s1(s1_if), .m(m_if),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int n, input logic vld, input logic op,
                         input logic [7:0] a, input logic [31:0] v);
        if (n == 0) begin
            s0_if.req_valid = vld; s0_if.req_opcode = op; s0_if.req_addr = a; s0_if.req_value = v;
        end else begin
            s1_if.req_valid = vld; s1_if.req_opcode = op; s1_if.req_addr = a; s1_if.req_value = v;
        end
    endtask

    // Present one request and wait (bounded) for its accept pulse; returns in the REQ cycle.
    task automatic send(input int n, input logic op, input logic [7:0] a,
                        input logic [31:0] v, output int waited);
        bit got;
        got    = 1'b0;
        waited = 0;
        exp_grant.push_back(n);
        drive(n, 1'b1, op, a, v);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = (n == 0) ? s0_if.req_deq : s1_if.req_deq;
            if (!got) waited++;
            tick();
        end
        drive(n, 1'b0, 1'b0, 8'h00, 32'h0);
        check("accept", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Scoreboard monitor: accept order and routed responses.
    always @(negedge clock) begin
        if (s0_if.req_deq && s1_if.req_deq)
            check("deq_both", 32'(s1_if.req_deq), 32'd0);
        if (s0_if.req_deq || s1_if.req_deq) begin
            if (exp_grant.size() == 0) check("deq_unexp", 32'(s0_if.req_deq | s1_if.req_deq), 32'd0);
            else check("grant_order", 32'(s1_if.req_deq), 32'(exp_grant.pop_front()));
        end
        if (s0_if.resp_valid) begin
            if (exp_resp0.size() == 0) check("resp0_unexp", 32'(s0_if.resp_valid), 32'd0);
            else check("resp0_data", s0_if.resp_bits, exp_resp0.pop_front());
        end
        if (s1_if.resp_valid) begin
            if (exp_resp1.size() == 0) check("resp1_unexp", 32'(s1_if.resp_valid), 32'd0);
            else check("resp1_data", s1_if.resp_bits, exp_resp1.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w;
        reset = 1'b0;
        drive(0, 1'b1, 1'b1, 8'h11, 32'h1);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
        m_if.req_deq = 1'b0; m_if.resp_valid = 1'b0; m_if.resp_bits = 32'h0;

        // Reset values, with a request present that must not be accepted.
        tick(); tick();
        @(negedge clock);
        check("rst_deq0", 32'(s0_if.req_deq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_mvalid", 32'(m_if.req_valid), 32'd0);
        check("rst_maddr", 32'(m_if.req_addr), 32'd0);
        check("rst_resp0", s0_if.resp_bits, 32'd0);
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Single write from s0.
        m_if.req_deq = 1'b1;
        send(0, 1'b1, 8'h10, 32'h12345678, w);
        check("wr_deq_cycle", 32'(w), 32'd0);
        @(negedge clock);
        check("wr_mvalid", 32'(m_if.req_valid), 32'd1);
        check("wr_maddr", 32'(m_if.req_addr), 32'h10);
        check("wr_mvalue", m_if.req_value, 32'h12345678);
        check("wr_mop", 32'(m_if.req_opcode), 32'd1);
        check("wr_busy1", 32'(busy), 32'd1);
        tick();
        @(negedge clock);
        check("wr_busy2", 32'(busy), 32'd0);
        check("wr_mvalid2", 32'(m_if.req_valid), 32'd0);
        tick();

        // Continuous contention after reset: grants alternate starting at 0.
        do_reset();
        tick();
        m_if.req_deq = 1'b1;
        for (int i = 0; i < 6; i++) exp_grant.push_back(i % 2);
        drive(0, 1'b1, 1'b1, 8'h20, 32'hA0);
        drive(1, 1'b1, 1'b1, 8'h21, 32'hB1);
        repeat (12) tick();
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        check("alt_all_granted", 32'(exp_grant.size()), 32'd0);

        // s1 read answered three cycles after the downstream accept.
        m_if.req_deq = 1'b0;
        send(1, 1'b0, 8'h04, 32'h0, w);
        m_if.req_deq = 1'b1;
        @(negedge clock);
        check("rd_maddr", 32'(m_if.req_addr), 32'h04);
        check("rd_mop", 32'(m_if.req_opcode), 32'd0);
        check("rd_grant", 32'(grant), 32'd1);
        tick();
        m_if.req_deq = 1'b0;
        tick();
        tick();
        m_if.resp_valid = 1'b1; m_if.resp_bits = 32'hCAFEF00D;
        exp_resp1.push_back(32'hCAFEF00D);
        tick();
        m_if.resp_valid = 1'b0;
        @(negedge clock);
        check("rd_s1_valid", 32'(s1_if.resp_valid), 32'd1);
        check("rd_s0_valid", 32'(s0_if.resp_valid), 32'd0);
        tick();
        @(negedge clock);
        check("rd_pulse", 32'(s1_if.resp_valid), 32'd0);
        check("rd_hold", s1_if.resp_bits, 32'hCAFEF00D);
        check("rd_busy", 32'(busy), 32'd0);
        tick();

        // s0 read never answered: watchdog fires 9 cycles after accept.
        send(0, 1'b0, 8'h24, 32'h0, w);
        m_if.req_deq = 1'b1;
        exp_resp0.push_back(32'hDEADBEEF);
        tick();
        m_if.req_deq = 1'b0;
        repeat (7) tick();
        @(negedge clock);
        check("to_early", 32'(s0_if.resp_valid), 32'd0);
        check("to_err_early", 32'(timeout_err), 32'd0);
        tick();
        @(negedge clock);
        check("to_valid", 32'(s0_if.resp_valid), 32'd1);
        check("to_err", 32'(timeout_err), 32'd1);
        tick();
        m_if.resp_valid = 1'b1; m_if.resp_bits = 32'h11111111;
        tick();
        m_if.resp_valid = 1'b0;
        @(negedge clock);
        check("late_drop", 32'(s0_if.resp_valid | s1_if.resp_valid), 32'd0);
        check("to_sticky", 32'(timeout_err), 32'd1);
        tick();

        // Reset in the middle of an s1 read abandons it.
        send(1, 1'b0, 8'h08, 32'h0, w);
        m_if.req_deq = 1'b1;
        tick();
        m_if.req_deq = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_grant", 32'(grant), 32'd0);
        check("mid_terr", 32'(timeout_err), 32'd0);
        check("mid_maddr", 32'(m_if.req_addr), 32'd0);
        tick();
        reset = 1'b1;
        m_if.resp_valid = 1'b1; m_if.resp_bits = 32'h22222222;
        tick();
        m_if.resp_valid = 1'b0;
        @(negedge clock);
        check("mid_no_resp", 32'(s1_if.resp_valid), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);
        tick();
        m_if.req_deq = 1'b1;
        send(1, 1'b1, 8'h30, 32'hA5A5A5A5, w);
        check("mid_next_cycle", 32'(w), 32'd0);
        @(negedge clock);
        check("mid_next_addr", 32'(m_if.req_addr), 32'h30);
        check("mid_next_grant", 32'(grant), 32'd1);
        tick();
        m_if.req_deq = 1'b0;

        // Response coinciding with the watchdog cycle wins.
        send(0, 1'b0, 8'h40, 32'h0, w);
        m_if.req_deq = 1'b1;
        tick();
        m_if.req_deq = 1'b0;
        repeat (7) tick();
        m_if.resp_valid = 1'b1; m_if.resp_bits = 32'h00000055;
        exp_resp0.push_back(32'h00000055);
        tick();
        m_if.resp_valid = 1'b0;
        @(negedge clock);
        check("race_valid", 32'(s0_if.resp_valid), 32'd1);
        check("race_terr", 32'(timeout_err), 32'd0);
        tick();
        @(negedge clock);
        check("race_terr2", 32'(timeout_err), 32'd0);

        check("sb_grant_empty", 32'(exp_grant.size()), 32'd0);
        check("sb_resp0_empty", 32'(exp_resp0.size()), 32'd0);
        check("sb_resp1_empty", 32'(exp_resp1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
